// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time/period capture with stall timeout; duty divider under PWM_CAPTURE_DUTY_EN
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             timeout,
    output logic             stuck_level
`ifdef PWM_CAPTURE_DUTY_EN
    ,
    output logic [6:0]       duty_pct,
    output logic             duty_valid
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1, s2, s3;
    logic             rise, fall, sat;
    logic [1:0]       state;
    logic [CNT_W-1:0] hacc, pacc;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
    // A rise in the saturating cycle still closes the measurement normally
    assign sat  = (pacc == CNT_MAX) && !rise;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            hacc        <= '0;
            pacc        <= '0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            if (!enable) begin
                state <= ST_IDLE;
                hacc  <= '0;
                pacc  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state <= ST_HIGH;
                            hacc  <= CNT_ONE;
                            pacc  <= CNT_ONE;
                        end else begin
                            hacc <= '0;
                            pacc <= '0;
                        end
                    end
                    ST_HIGH: begin
                        if (sat) begin
                            timeout     <= 1'b1;
                            stuck_level <= s2;
                            state       <= ST_IDLE;
                            hacc        <= '0;
                            pacc        <= '0;
                        end else if (fall) begin
                            state <= ST_LOW;
                            pacc  <= pacc + CNT_ONE;
                        end else begin
                            hacc <= hacc + CNT_ONE;
                            pacc <= pacc + CNT_ONE;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            high_cnt   <= hacc;
                            period_cnt <= pacc;
                            valid      <= 1'b1;
                            state      <= ST_HIGH;
                            hacc       <= CNT_ONE;
                            pacc       <= CNT_ONE;
                        end else if (sat) begin
                            timeout     <= 1'b1;
                            stuck_level <= s2;
                            state       <= ST_IDLE;
                            hacc        <= '0;
                            pacc        <= '0;
                        end else begin
                            pacc <= pacc + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        hacc  <= '0;
                        pacc  <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PWM_CAPTURE_DUTY_EN
    // Restoring division of high*100 by period; the quotient never exceeds 100 so 7 bits suffice
    localparam int NW = CNT_W + 7;

    logic [NW-1:0] rem, dsh, rem_sub;
    logic [6:0]    quo, quo_nx;
    logic [2:0]    iter;
    logic          take;

    assign take    = (rem >= dsh);
    assign rem_sub = rem - dsh;
    assign quo_nx  = {quo[5:0], take};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem        <= '0;
            dsh        <= '0;
            quo        <= '0;
            iter       <= 3'd0;
            duty_pct   <= 7'd0;
            duty_valid <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (valid) begin
                rem  <= NW'(high_cnt) * NW'(100);
                dsh  <= NW'(period_cnt) << 6;
                quo  <= 7'd0;
                iter <= 3'd7;
            end else if (iter != 3'd0) begin
                if (take) begin
                    rem <= rem_sub;
                end
                dsh  <= dsh >> 1;
                quo  <= quo_nx;
                iter <= iter - 3'd1;
                if (iter == 3'd1) begin
                    duty_pct   <= quo_nx;
                    duty_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed bench for pwm_capture with an edge-time model of each measurement
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int CNT_W = 8;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clock  = 1'b0;
    logic             reset  = 1'b0;
    logic             enable = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_cnt, period_cnt;
    logic             valid, timeout, stuck_level;
`ifdef PWM_CAPTURE_DUTY_EN
    logic [6:0]       duty_pct;
    logic             duty_valid;
`endif

    int checks = 0;
    int errors = 0;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .pwm_in      (pwm_in),
        .high_cnt    (high_cnt),
        .period_cnt  (period_cnt),
        .valid       (valid),
        .timeout     (timeout),
        .stuck_level (stuck_level)
`ifdef PWM_CAPTURE_DUTY_EN
        ,
        .duty_pct    (duty_pct),
        .duty_valid  (duty_valid)
`endif
    );

    always #5 clock = ~clock;

    // Model: pw[n] is pwm_in at edge n; the FSM acts on the level two edges old.
    // A measurement is rise time, fall time and next rise time, all in edge numbers.
    bit pw[$];
    int n        = 0;
    int rst_mark = 0;
    bit armed    = 1'b0;
    int rise_t   = 0;
    int fall_t   = 0;
    int m_high   = 0;
    int m_period = 0;
    bit m_valid  = 1'b0;
    bit m_timeout = 1'b0;
    bit m_stuck  = 1'b0;
    int m_duty   = 0;
    bit m_dv     = 1'b0;
    bit d_pend   = 1'b0;
    int d_due    = 0;
    int d_val    = 0;

    function automatic bit smp(input int i);
        if (i < 0 || i < rst_mark) return 1'b0;
        return pw[i];
    endfunction

    always @(posedge clock) begin
        bit lvl, prv;
        pw.push_back(pwm_in);
        m_valid   = 1'b0;
        m_timeout = 1'b0;
        m_dv      = 1'b0;
        if (!reset) begin
            rst_mark = n + 1;
            armed    = 1'b0;
            m_high   = 0;
            m_period = 0;
            m_stuck  = 1'b0;
            m_duty   = 0;
            d_pend   = 1'b0;
        end else begin
            lvl = smp(n - 2);
            prv = smp(n - 3);
            if (d_pend && d_due == n) begin
                m_dv   = 1'b1;
                m_duty = d_val;
                d_pend = 1'b0;
            end
            if (!enable) begin
                armed = 1'b0;
            end else if (lvl && !prv) begin
                if (armed) begin
                    m_high   = fall_t - rise_t;
                    m_period = n - rise_t;
                    m_valid  = 1'b1;
                    d_pend   = 1'b1;
                    d_due    = n + 8;
                    d_val    = (m_high * 100) / m_period;
                end
                armed  = 1'b1;
                rise_t = n;
            end else if (armed) begin
                if (!lvl && prv) fall_t = n;
                if (n - rise_t == SAT) begin
                    m_timeout = 1'b1;
                    m_stuck   = lvl;
                    armed     = 1'b0;
                end
            end
        end
        n++;
    end

    int cyc = 0, nprint = 0;
    int vcount = 0, last_vcyc = 0, prev_vcyc = 0, tcount = 0;
    int dvcount = 0, last_dvcyc = 0;
    int e_h, e_p, e_d;
    bit e_v, e_t, e_s, e_dv;
    int v0, t0, dv0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic drive(input bit p, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            pwm_in = p;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clock);
                cyc++;
                if (!reset) begin
                    e_h = 0; e_p = 0; e_v = 1'b0; e_t = 1'b0; e_s = 1'b0; e_d = 0; e_dv = 1'b0;
                end else begin
                    e_h = m_high; e_p = m_period; e_v = m_valid; e_t = m_timeout;
                    e_s = m_stuck; e_d = m_duty; e_dv = m_dv;
                end
                checks++;
                if (int'(high_cnt) != e_h || int'(period_cnt) != e_p || valid !== e_v ||
                    timeout !== e_t || stuck_level !== e_s) begin
                    errors++;
                    if (nprint < 20)
                        $display("FAIL cycle %0d outputs: got high=%0d period=%0d valid=%0b timeout=%0b stuck=%0b, want high=%0d period=%0d valid=%0b timeout=%0b stuck=%0b",
                                 cyc, high_cnt, period_cnt, valid, timeout, stuck_level, e_h, e_p, e_v, e_t, e_s);
                    nprint++;
                end
                if (valid) begin
                    vcount++;
                    prev_vcyc = last_vcyc;
                    last_vcyc = cyc;
                end
                if (timeout) tcount++;
`ifdef PWM_CAPTURE_DUTY_EN
                checks++;
                if (int'(duty_pct) != e_d || duty_valid !== e_dv) begin
                    errors++;
                    if (nprint < 20)
                        $display("FAIL cycle %0d duty: got duty_pct=%0d duty_valid=%0b, want duty_pct=%0d duty_valid=%0b",
                                 cyc, duty_pct, duty_valid, e_d, e_dv);
                    nprint++;
                end
                if (duty_valid) begin
                    dvcount++;
                    last_dvcyc = cyc;
                end
`endif
            end
        join_none

        repeat (3) @(posedge clock);
        #1;
        chk("reset high_cnt", int'(high_cnt), 0);
        chk("reset period_cnt", int'(period_cnt), 0);
        chk("reset valid", int'(valid), 0);
        chk("reset timeout", int'(timeout), 0);
        chk("reset stuck_level", int'(stuck_level), 0);
`ifdef PWM_CAPTURE_DUTY_EN
        chk("reset duty_pct", int'(duty_pct), 0);
`endif
        reset  = 1'b1;
        enable = 1'b1;

        // Generator-shaped 2/18 waveform, five rises
        v0 = vcount; dv0 = dvcount;
        wave(2, 18, 5);
        chk("gen valid count", vcount - v0, 4);
        chk("gen high_cnt", int'(high_cnt), 2);
        chk("gen period_cnt", int'(period_cnt), 20);
        chk("gen valid spacing", last_vcyc - prev_vcyc, 20);
`ifdef PWM_CAPTURE_DUTY_EN
        chk("gen duty_valid count", dvcount - dv0, 4);
        chk("gen duty_pct", int'(duty_pct), 10);
        chk("gen duty latency", last_dvcyc - last_vcyc, 8);
`endif

        // Stuck low after the waveform
        v0 = vcount; t0 = tcount;
        drive(1'b0, 300);
        chk("stuck-low timeout count", tcount - t0, 1);
        chk("stuck-low stuck_level", int'(stuck_level), 0);
        chk("stuck-low high_cnt kept", int'(high_cnt), 2);
        chk("stuck-low period_cnt kept", int'(period_cnt), 20);
        chk("stuck-low no valid", vcount - v0, 0);

        // 5/10 resumes only after two rises
        v0 = vcount;
        wave(5, 5, 4);
        chk("resume valid count", vcount - v0, 3);
        chk("resume high_cnt", int'(high_cnt), 5);
        chk("resume period_cnt", int'(period_cnt), 10);
        drive(1'b0, 300);
`ifdef PWM_CAPTURE_DUTY_EN
        chk("resume duty_pct", int'(duty_pct), 50);
`endif

        // Stuck high from IDLE
        v0 = vcount; t0 = tcount;
        drive(1'b1, 300);
        chk("stuck-high timeout count", tcount - t0, 1);
        chk("stuck-high stuck_level", int'(stuck_level), 1);
        chk("stuck-high no valid", vcount - v0, 0);
        chk("stuck-high high_cnt kept", int'(high_cnt), 5);
        chk("stuck-high period_cnt kept", int'(period_cnt), 10);

        // enable dropped mid-period
        drive(1'b0, 5);
        v0 = vcount;
        wave(3, 7, 3);
        drive(1'b1, 3);
        drive(1'b0, 2);
        chk("pre-drop valid count", vcount - v0, 3);
        v0 = vcount; t0 = tcount;
        enable = 1'b0;
        drive(1'b0, 5);
        wave(3, 7, 2);
        chk("disabled no valid", vcount - v0, 0);
        chk("disabled no timeout", tcount - t0, 0);
        chk("disabled high_cnt kept", int'(high_cnt), 3);
        chk("disabled period_cnt kept", int'(period_cnt), 10);
        enable = 1'b1;
        v0 = vcount;
        wave(4, 6, 3);
        drive(1'b1, 4);
        chk("re-enable valid count", vcount - v0, 3);
        chk("re-enable high_cnt", int'(high_cnt), 4);
        chk("re-enable period_cnt", int'(period_cnt), 10);

        // Asynchronous reset mid-HIGH
        #2 reset = 1'b0;
        #1;
        chk("async reset high_cnt", int'(high_cnt), 0);
        chk("async reset period_cnt", int'(period_cnt), 0);
        chk("async reset stuck_level", int'(stuck_level), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        drive(1'b1, 3);
        drive(1'b0, 7);

        // Duty extremes: back-to-back 1/3 periods
        v0 = vcount; dv0 = dvcount;
        wave(1, 2, 4);
        drive(1'b0, 12);
        chk("short valid count", vcount - v0, 4);
        chk("short high_cnt", int'(high_cnt), 1);
        chk("short period_cnt", int'(period_cnt), 3);
`ifdef PWM_CAPTURE_DUTY_EN
        chk("short duty_valid count", dvcount - dv0, 1);
        chk("short duty_pct", int'(duty_pct), 33);
`endif

        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform, such as the output of the team's PWM generator, and reports the high time and period of each complete cycle in clock ticks. It sits directly downstream of the generator in the servo and LED drive path. It provides loop-back checking in hardware and gives firmware readback of the actual duty delivered. It also flags a stalled (stuck-high or stuck-low) signal.

## Interface
- CNT_W, 16, width of the high-time and period measurement counters.
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  measurement enable; low forces IDLE.
- pwm_in  input  1  asynchronous PWM input.
- high_cnt  output  CNT_W  high time of the last complete cycle, in clocks.
- period_cnt  output  CNT_W  rise-to-rise period of the last complete cycle, in clocks.
- valid  output  1  one-cycle pulse when high_cnt/period_cnt update.
- timeout  output  1  one-cycle pulse when no rising edge is seen before the period counter saturates.
- stuck_level  output  1  synchronized pwm_in level captured at the last timeout.
- duty_pct  output  7  floor(high_cnt*100/period_cnt). Present only with PWM_CAPTURE_DUTY_EN.
- duty_valid  output  1  one-cycle pulse when duty_pct updates. Present only with PWM_CAPTURE_DUTY_EN.

## Operation
- Synchronizer: s1 <= pwm_in, s2 <= s1, s3 <= s2.
  - rise = s2 & ~s3
  - fall = ~s2 & s3
  - All decisions use rise, fall and s2 only.
- Internal accumulators: hacc and pacc, each CNT_W bits.
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - hacc and pacc are held at 0.
  - On rise: go to HIGH with hacc=1, pacc=1.
- HIGH, on a cycle without fall: hacc++, pacc++.
- HIGH, on fall: go to LOW, pacc++ (hacc unchanged).
- LOW, on a cycle without rise: pacc++.
- LOW, on rise:
  - high_cnt<=hacc, period_cnt<=pacc, valid<=1.
  - Go to HIGH with hacc=1, pacc=1.
- Saturation: in HIGH or LOW, when pacc==2^CNT_W-1 and no rise in that cycle:
  - timeout<=1, stuck_level<=s2, go to IDLE.
  - high_cnt and period_cnt are unchanged.
- enable low: go to IDLE and clear the accumulators.
  - high_cnt, period_cnt and stuck_level retain their values.
  - valid and timeout are 0.
- Re-enabling starts from IDLE. The first partial cycle after any entry to IDLE never produces valid.
- Arithmetic: hacc never exceeds pacc, so high_cnt <= period_cnt always holds.

## Timing
- Reset values: high_cnt=0, period_cnt=0, valid=0, timeout=0, stuck_level=0, duty_pct=0, duty_valid=0. Synchronizer flops are 0 and the FSM is in IDLE.
- Input latency: pwm_in rising at sample edge k is seen as rise during the cycle after edge k+1. valid is high after edge k+2, for exactly one cycle.
- valid and timeout are mutually exclusive. A rise in the saturation cycle takes priority: the measurement is reported and no timeout occurs.
- Reset deasserted mid-measurement restarts in IDLE. No valid is produced until two rising edges have been seen.

## Configuration
- Macro: PWM_CAPTURE_DUTY_EN.
- Defined: a sequential restoring divider computes duty_pct from the latched high_cnt and period_cnt.
  - Load on the valid cycle, then 7 quotient iterations.
  - duty_valid pulses exactly 8 cycles after valid.
  - A new valid during a divide abandons it and restarts with the new values; duty_valid fires only for the latest one.
  - duty_pct holds between updates.
- Undefined: the duty_pct and duty_valid ports and the divider logic are absent.

## Test plan
- Generator-shaped input: pwm_in high 2 clocks, low 18, repeated with enable=1.
  - The first valid appears after the second rising edge.
  - Every valid reports high_cnt=2, period_cnt=20, spaced 20 clocks apart.
  - With the macro: duty_pct=10, 8 cycles after each valid.
- Stuck high: CNT_W=8, pwm_in rises once and stays high.
  - One timeout pulse, stuck_level=1.
  - high_cnt and period_cnt unchanged; valid never fires.
- Stuck low: CNT_W=8, pwm_in low after one rise.
  - One timeout, stuck_level=0.
  - A later 5/10 waveform resumes with valid only after two rises: high_cnt=5, period_cnt=10.
- enable dropped mid-period: no valid; outputs keep their old values. After re-enable, the first valid needs two new rises.
- Asynchronous reset asserted mid-HIGH: all outputs return to reset values immediately; operation restarts from IDLE.
- Duty extremes with the macro: high 1 of 3 gives duty_pct=33. Back-to-back 3-clock periods restart the divider; only the last result pulses duty_valid.
